ke_inv_seq: RTL and testbench
=============================

Name: ke_inv_seq

Overview:
- Sequential inverse AES-128 key schedule for the decryption datapath.
- Loaded with the final round key (round NR); walks the schedule backwards one round per accepted output. Emits round keys NR, NR-1, ... 0 in the order the inverse cipher consumes them.
- Exact counterpart of the forward ke_core step (word_in, i -> word_out), which produces key i from key i-1: ke_inv_seq recovers key i-1 from key i.
- Has its own 4-S-box SubWord and Rcon table; no dependence on ke_core.

Parameters:
NR, 10, index of the loaded key; legal 1..10, and rk_round counts down from NR to 0 (AES-128 only).

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous active-high reset
start  input  1  load request; sampled only in IDLE
key_in  input  128  round-NR key; w0 = [127:96], w3 = [31:0]
rk_ready  input  1  consumer accepts rk_out this cycle
rk_out  output  128  current round key, same word order
rk_round  output  4  round index of rk_out
rk_valid  output  1  rk_out/rk_round valid
busy  output  1  high from start acceptance until final handshake
done  output  1  one-cycle pulse after round-0 key accepted

Behaviour:
- Reset values:
  - rk_out = 0, rk_round = 0, rk_valid = 0, busy = 0, done = 0.
  - State = IDLE.
- States: IDLE, OUT.
- IDLE, start = 1:
  - Next cycle: rk_out = key_in, rk_round = NR, rk_valid = 1, busy = 1, state = OUT.
  - Latency is 1 cycle.
  - key_in is captured only on this edge.
- OUT: rk_out and rk_round are held stable while rk_valid = 1 and rk_ready = 0.
- OUT, rk_ready = 1, rk_round > 0: next cycle rk_out = prev(rk_out, rk_round), rk_round = rk_round - 1, rk_valid stays 1. One key per cycle under continuous ready.
- OUT, rk_ready = 1, rk_round = 0:
  - Next cycle: rk_valid = 0, busy = 0, done = 1 for exactly one cycle, state = IDLE.
  - rk_out keeps the round-0 key.
- prev(w, i), with w = {w0, w1, w2, w3}:
  - p3 = w3 ^ w2
  - p2 = w2 ^ w1
  - p1 = w1 ^ w0
  - p0 = w0 ^ SubWord(RotWord(p3)) ^ {Rcon[i], 24'h0}
  - RotWord({a, b, c, d}) = {b, c, d, a}.
  - SubWord = bytewise AES S-box.
  - Rcon[1..10] = 01, 02, 04, 08, 10, 20, 40, 80, 1b, 36.
  - Result = {p0, p1, p2, p3}.
- start while busy: ignored, with no effect on key, round or handshake.
- start asserted in the same cycle as the final handshake: ignored. A new run needs start in a cycle where state = IDLE.
- done and start back-to-back: start in the cycle done = 1 is accepted (state is IDLE).
- rst has priority over everything. rst mid-run returns all outputs to reset values next cycle; no done pulse.
- Total run under continuous ready: NR+1 valid cycles, then done.

Test Plan:
- Reset then start with key_in = d014f9a8c9ee2589e13f0cc8b6630ca6, rk_ready held 1 -> rk_out sequence:
  - round 10: d014f9a8c9ee2589e13f0cc8b6630ca6
  - round 9: ac7766f319fadc2128d12941575c006e
  - round 1: a0fafe1788542cb123a339392a6c7605
  - round 0: 2b7e151628aed2a6abf7158809cf4f3c
  - then done = 1 for one cycle, busy = 0.
- Same run with rk_ready toggling 1,0,0,1,... -> key/round held across stall cycles; the 11-key sequence is identical and gap-free.
- NR = 1, key_in = a0fafe1788542cb123a339392a6c7605 -> outputs round 1 that key, then round 0 2b7e151628aed2a6abf7158809cf4f3c, done.
- start pulsed at round 5 with a different key_in -> no effect; sequence completes unchanged.
- rst asserted while rk_round = 6 -> next cycle rk_valid = 0, busy = 0, rk_out = 0, no done. A fresh start then yields round 10 correctly.
- start in the done cycle -> accepted; rk_valid = 1 next cycle with the new key and rk_round = NR.

Source files
------------

// File: rtl/ke_inv_seq.sv
// ke_inv_seq -- sequential inverse AES-128 key schedule.
//
// Loaded with the round-NR key, then walks the key schedule backwards and
// emits one round key per accepted handshake: rounds NR, NR-1, ..., 0.
// Each backward step undoes one forward key-expansion step, recovering
// round key i-1 from round key i.
//
// Ports:
//   clk       in   1    system clock, all state on the rising edge
//   rst       in   1    synchronous active-high reset
//   start     in   1    load request, sampled only while idle
//   key_in    in   128  round-NR key, w0 = [127:96] ... w3 = [31:0]
//   rk_ready  in   1    consumer accepts rk_out this cycle
//   rk_out    out  128  current round key, same word order as key_in
//   rk_round  out  4    round index of rk_out
//   rk_valid  out  1    rk_out / rk_round valid
//   busy      out  1    high from start acceptance until the final handshake
//   done      out  1    one-cycle pulse after the round-0 key is accepted
module ke_inv_seq #(
    parameter int unsigned NR = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key_in,
    input  logic         rk_ready,
    output logic [127:0] rk_out,
    output logic [3:0]   rk_round,
    output logic         rk_valid,
    output logic         busy,
    output logic         done
);

    typedef enum logic {
        IDLE = 1'b0,
        OUT  = 1'b1
    } state_e;

    localparam logic [3:0] NR_ROUND = 4'(NR);

    // AES S-box, element 0 in the most significant byte.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        sub_word = {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    endfunction

    state_e       state_q;
    logic [127:0] key_q;
    logic [3:0]   round_q;
    logic         valid_q;
    logic         busy_q;
    logic         done_q;

    // Backward step: the XOR chain of the forward schedule is undone from
    // w3 down to w1; w0 is then recovered using the restored old w3 (= p3),
    // which is exactly the word the forward step fed through RotWord/SubWord.
    logic [31:0]  p0, p1, p2, p3;
    logic [127:0] prev_key_d;

    assign p3 = key_q[31:0]   ^ key_q[63:32];
    assign p2 = key_q[63:32]  ^ key_q[95:64];
    assign p1 = key_q[95:64]  ^ key_q[127:96];
    assign p0 = key_q[127:96] ^ sub_word({p3[23:0], p3[31:24]}) ^ {rcon(round_q), 24'h0};
    assign prev_key_d = {p0, p1, p2, p3};

    // NOTE: all state below uses non-blocking assignments so every register
    // samples the pre-edge values of the others, regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            key_q   <= '0;
            round_q <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        key_q   <= key_in;
                        round_q <= NR_ROUND;
                        valid_q <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= OUT;
                    end
                end
                OUT: begin
                    // start is deliberately ignored here, including on the
                    // final handshake; a new run needs start while idle.
                    if (rk_ready) begin
                        if (round_q != 4'd0) begin
                            key_q   <= prev_key_d;
                            round_q <= round_q - 4'd1;
                        end else begin
                            // round-0 key stays on rk_out after the run ends
                            valid_q <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rk_out   = key_q;
    assign rk_round = round_q;
    assign rk_valid = valid_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_ke_inv_seq.sv
// Directed testbench for ke_inv_seq using the FIPS-197 AES-128 example key
// schedule (cipher key 2b7e1516...) as the reference round keys.
module tb_ke_inv_seq;

    logic         clk = 1'b0;
    logic         rst;
    logic         start, start1;
    logic [127:0] key_in, key_in1;
    logic         rk_ready, rk_ready1;
    logic [127:0] rk_out, rk_out1;
    logic [3:0]   rk_round, rk_round1;
    logic         rk_valid, rk_valid1;
    logic         busy, busy1;
    logic         done, done1;

    always #5 clk = ~clk;

    ke_inv_seq #(.NR(10)) u_dut (
        .clk(clk), .rst(rst), .start(start), .key_in(key_in), .rk_ready(rk_ready),
        .rk_out(rk_out), .rk_round(rk_round), .rk_valid(rk_valid), .busy(busy), .done(done)
    );

    ke_inv_seq #(.NR(1)) u_nr1 (
        .clk(clk), .rst(rst), .start(start1), .key_in(key_in1), .rk_ready(rk_ready1),
        .rk_out(rk_out1), .rk_round(rk_round1), .rk_valid(rk_valid1), .busy(busy1), .done(done1)
    );

    // FIPS-197 Appendix A.1 round keys, indexed by round.
    localparam logic [127:0] RK [0:10] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c,
        128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f,
        128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00,
        128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd,
        128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f,
        128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };

    int checks = 0;
    int errors = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        start = 1'b0; start1 = 1'b0;
        rk_ready = 1'b0; rk_ready1 = 1'b0;
        key_in = '0; key_in1 = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        key_in = RK[5];
        key_in1 = RK[5];
        do_reset();
        checks++;
        if (rk_out !== '0 || rk_round !== 4'd0 || rk_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_nr10: out=%h round=%0d valid=%b busy=%b done=%b, want all zero",
                     rk_out, rk_round, rk_valid, busy, done);
        end
        checks++;
        if (rk_out1 !== '0 || rk_round1 !== 4'd0 || rk_valid1 !== 1'b0 || busy1 !== 1'b0 || done1 !== 1'b0) begin
            errors++;
            $display("FAIL reset_nr1: out=%h round=%0d valid=%b busy=%b done=%b, want all zero",
                     rk_out1, rk_round1, rk_valid1, busy1, done1);
        end
    endtask

    // Continuous-ready run; optionally pulses start with a foreign key while
    // the given round is on the output (must have no effect).
    task automatic run_continuous(input string tag, input int inject_round);
        start = 1'b1; key_in = RK[10]; rk_ready = 1'b1;
        step();
        start = 1'b0;
        for (int r = 10; r >= 0; r--) begin
            checks++;
            if (rk_valid !== 1'b1 || busy !== 1'b1 || done !== 1'b0 || rk_round !== 4'(r) || rk_out !== RK[r]) begin
                errors++;
                $display("FAIL %s_r%0d: valid=%b busy=%b done=%b round=%0d key=%h, want 1 1 0 round=%0d key=%h",
                         tag, r, rk_valid, busy, done, rk_round, rk_out, r, RK[r]);
            end
            if (r == inject_round) begin
                start = 1'b1;
                key_in = RK[3];
            end else begin
                start = 1'b0;
            end
            step();
        end
        start = 1'b0;
        checks++;
        if (rk_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b1 || rk_out !== RK[0]) begin
            errors++;
            $display("FAIL %s_done: valid=%b busy=%b done=%b key=%h, want 0 0 1 key=%h",
                     tag, rk_valid, busy, done, rk_out, RK[0]);
        end
        step();
        checks++;
        if (done !== 1'b0 || rk_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_done_pulse: done=%b valid=%b, want 0 0", tag, done, rk_valid);
        end
    endtask

    task automatic test_continuous();
        run_continuous("cont", -1);
    endtask

    task automatic test_start_while_busy();
        run_continuous("busy_start", 5);
    endtask

    task automatic test_stall();
        int  exp_r;
        bit  fin;
        start = 1'b1; key_in = RK[10]; rk_ready = 1'b0;
        step();
        start = 1'b0;
        exp_r = 10;
        fin = 1'b0;
        for (int c = 0; c < 100 && !fin; c++) begin
            rk_ready = ((c % 3) == 0);
            checks++;
            if (rk_valid !== 1'b1 || rk_round !== 4'(exp_r) || rk_out !== RK[exp_r]) begin
                errors++;
                $display("FAIL stall_c%0d: valid=%b round=%0d key=%h, want 1 round=%0d key=%h",
                         c, rk_valid, rk_round, rk_out, exp_r, RK[exp_r]);
            end
            step();
            if (rk_ready) begin
                if (exp_r == 0) fin = 1'b1;
                else exp_r--;
            end
        end
        rk_ready = 1'b0;
        checks++;
        if (!fin || done !== 1'b1 || rk_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL stall_end: finished=%b done=%b valid=%b busy=%b, want 1 1 0 0",
                     fin, done, rk_valid, busy);
        end
        step();
    endtask

    task automatic test_nr1();
        start1 = 1'b1; key_in1 = RK[1]; rk_ready1 = 1'b1;
        step();
        start1 = 1'b0;
        checks++;
        if (rk_valid1 !== 1'b1 || rk_round1 !== 4'd1 || rk_out1 !== RK[1]) begin
            errors++;
            $display("FAIL nr1_r1: valid=%b round=%0d key=%h, want 1 1 %h", rk_valid1, rk_round1, rk_out1, RK[1]);
        end
        step();
        checks++;
        if (rk_valid1 !== 1'b1 || rk_round1 !== 4'd0 || rk_out1 !== RK[0]) begin
            errors++;
            $display("FAIL nr1_r0: valid=%b round=%0d key=%h, want 1 0 %h", rk_valid1, rk_round1, rk_out1, RK[0]);
        end
        step();
        checks++;
        if (done1 !== 1'b1 || rk_valid1 !== 1'b0 || busy1 !== 1'b0) begin
            errors++;
            $display("FAIL nr1_done: done=%b valid=%b busy=%b, want 1 0 0", done1, rk_valid1, busy1);
        end
        rk_ready1 = 1'b0;
        step();
    endtask

    task automatic test_rst_mid_run();
        start = 1'b1; key_in = RK[10]; rk_ready = 1'b1;
        step();
        start = 1'b0;
        for (int r = 10; r >= 6; r--) begin
            checks++;
            if (rk_round !== 4'(r) || rk_out !== RK[r]) begin
                errors++;
                $display("FAIL rst_run_r%0d: round=%0d key=%h, want round=%0d key=%h", r, rk_round, rk_out, r, RK[r]);
            end
            if (r == 6) rst = 1'b1;
            step();
        end
        checks++;
        if (rk_valid !== 1'b0 || busy !== 1'b0 || rk_out !== '0 || rk_round !== 4'd0 || done !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid: valid=%b busy=%b out=%h round=%0d done=%b, want all zero",
                     rk_valid, busy, rk_out, rk_round, done);
        end
        rst = 1'b0;
        step();
        checks++;
        if (done !== 1'b0 || rk_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_no_done: done=%b valid=%b, want 0 0", done, rk_valid);
        end
        start = 1'b1; key_in = RK[10];
        step();
        start = 1'b0;
        checks++;
        if (rk_valid !== 1'b1 || rk_round !== 4'd10 || rk_out !== RK[10]) begin
            errors++;
            $display("FAIL rst_restart: valid=%b round=%0d key=%h, want 1 10 %h", rk_valid, rk_round, rk_out, RK[10]);
        end
        step();
        checks++;
        if (rk_round !== 4'd9 || rk_out !== RK[9]) begin
            errors++;
            $display("FAIL rst_restart_r9: round=%0d key=%h, want 9 %h", rk_round, rk_out, RK[9]);
        end
        do_reset();
    endtask

    task automatic test_done_start();
        start = 1'b1; key_in = RK[10]; rk_ready = 1'b1;
        step();
        start = 1'b0;
        for (int r = 10; r > 0; r--) step();
        checks++;
        if (rk_round !== 4'd0 || rk_out !== RK[0]) begin
            errors++;
            $display("FAIL done_start_r0: round=%0d key=%h, want 0 %h", rk_round, rk_out, RK[0]);
        end
        // start on the final handshake must be ignored
        start = 1'b1; key_in = RK[1];
        step();
        checks++;
        if (done !== 1'b1 || rk_valid !== 1'b0 || busy !== 1'b0 || rk_out !== RK[0]) begin
            errors++;
            $display("FAIL handshake_start_ignored: done=%b valid=%b busy=%b key=%h, want 1 0 0 %h",
                     done, rk_valid, busy, rk_out, RK[0]);
        end
        // start held into the done cycle is accepted
        step();
        start = 1'b0;
        checks++;
        if (rk_valid !== 1'b1 || busy !== 1'b1 || done !== 1'b0 || rk_round !== 4'd10 || rk_out !== RK[1]) begin
            errors++;
            $display("FAIL done_start_accept: valid=%b busy=%b done=%b round=%0d key=%h, want 1 1 0 10 %h",
                     rk_valid, busy, done, rk_round, rk_out, RK[1]);
        end
        do_reset();
    endtask

    initial begin
        rst = 1'b1;
        test_reset();
        test_continuous();
        test_stall();
        test_start_while_busy();
        test_nr1();
        test_rst_mid_run();
        test_done_start();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
